// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_pkg
// Description : Shared types and constants for the trace-capture unit:
//               controller state encoding and capture-mode codes.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Controller states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Capture-mode codes as presented on mode_i
    localparam logic [1:0] MODE_ALL  = 2'b00;  // sample every cycle
    localparam logic [1:0] MODE_PC   = 2'b01;  // sample when PC changes
    localparam logic [1:0] MODE_CH   = 2'b10;  // sample when any channel changes
    localparam logic [1:0] MODE_RSVD = 2'b11;  // reserved, behaves as MODE_ALL

    // Reserved mode falls back to unconditional sampling
    function automatic logic mode_is_all(input logic [1:0] mode);
        return (mode == MODE_ALL) || (mode == MODE_RSVD);
    endfunction

endpackage : trace_pkg
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo
// Description : Show-ahead synchronous FIFO. The head entry is presented
//               combinationally on o_data; a pop advances to the next entry
//               on the following cycle. Flush empties the FIFO and takes
//               priority over push and pop in the same cycle. A push into a
//               full FIFO is accepted only when a pop happens alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A pop needs data; a push needs space, or a pop freeing a slot this cycle
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage array: written at the tail, not reset (contents are only
    // meaningful between the pointers)
    always_ff @(posedge clock) begin
        if (w_push && !i_flush && !reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : trace_fifo
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture
// Description : Records per-cycle snapshots of PC, instruction and a set of
//               watched register channels into an on-chip buffer during a
//               bounded capture window started by arm_i. Samples can be taken
//               every cycle, on PC change, or on any channel change. The
//               buffer drains through a show-ahead valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int PC_WIDTH    = 64,
    parameter int NUM_CH      = 3,
    parameter int DEPTH       = 16,
    parameter int STOP_CYCLES = 750
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PC_WIDTH-1:0]          pc_i,
    input  logic [31:0]                  instruction_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
    input  logic [1:0]                   mode_i,
    input  logic                         arm_i,
    input  logic                         rd_ready_i,
    output logic                         rd_valid_o,
    output logic [PC_WIDTH-1:0]          rd_pc_o,
    output logic [31:0]                  rd_instr_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_ch_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         overflow_o,
    output logic                         done_o
);

    localparam int CHW = NUM_CH * DATA_WIDTH;
    localparam int FW  = PC_WIDTH + 32 + CHW;
    // Counter must hold 0..STOP_CYCLES-1; keep at least one bit
    localparam int CW  = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam logic [CW-1:0] c_last_cycle = CW'(STOP_CYCLES - 1);

    state_e                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [1:0]             r_mode;
    logic                   r_first;
    logic                   r_overflow;
    logic [PC_WIDTH-1:0]    r_prev_pc;
    logic [CHW-1:0]         r_prev_ch;

    logic                   w_capture;
    logic                   w_qual;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [FW-1:0]          w_wr_data;
    logic [FW-1:0]          w_rd_data;
    logic [$clog2(DEPTH):0] w_count;

    // An arm pulse restarts the window and flushes the buffer, so no sample
    // is taken in the arm cycle itself
    assign w_capture = (r_state == ST_CAPTURE) && !arm_i;

    // Sample qualifier; the first window cycle has no valid previous value
    always_comb begin
        w_qual = 1'b0;
        if (r_first || mode_is_all(r_mode)) begin
            w_qual = 1'b1;
        end else if (r_mode == MODE_PC) begin
            w_qual = (pc_i != r_prev_pc);
        end else if (r_mode == MODE_CH) begin
            w_qual = (ch_data_i != r_prev_ch);
        end
    end

    assign w_push    = w_capture && w_qual;
    assign w_pop     = rd_valid_o && rd_ready_i;
    // A qualifying sample is lost only if the buffer is full and not draining
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_wr_data = {pc_i, instruction_i, ch_data_i};

    trace_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (arm_i),
        .i_data  (w_wr_data),
        .o_data  (w_rd_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Controller: arming from any state, window counting, overflow tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_mode     <= MODE_ALL;
            r_first    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (arm_i) begin
            r_state    <= ST_CAPTURE;
            r_cnt      <= '0;
            r_mode     <= mode_i;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    r_first <= 1'b0;
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_cnt == c_last_cycle) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Previous-cycle copies of the watched values for change detection
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_pc <= '0;
            r_prev_ch <= '0;
        end else begin
            r_prev_pc <= pc_i;
            r_prev_ch <= ch_data_i;
        end
    end

    assign rd_valid_o = !w_empty;
    assign rd_pc_o    = w_rd_data[FW-1 -: PC_WIDTH];
    assign rd_instr_o = w_rd_data[CHW +: 32];
    assign rd_ch_o    = w_rd_data[CHW-1:0];
    assign count_o    = w_count;
    assign overflow_o = r_overflow;
    assign done_o     = (r_state == ST_DONE);

endmodule : trace_capture
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_capture
// Description : Self-checking bench for trace_capture. Directed scenarios
//               with randomized data, plus a random soak, all compared every
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_capture;

    localparam int DW   = 16;
    localparam int PW   = 32;
    localparam int NCH  = 3;
    localparam int DEP  = 16;
    localparam int STOP = 20;
    localparam int CHW  = NCH * DW;

    logic             clk;
    logic             rst;
    logic [PW-1:0]    pc;
    logic [31:0]      instr;
    logic [CHW-1:0]   ch;
    logic [1:0]       mode;
    logic             arm;
    logic             ready;
    logic             rd_valid;
    logic [PW-1:0]    rd_pc;
    logic [31:0]      rd_instr;
    logic [CHW-1:0]   rd_ch;
    logic [$clog2(DEP):0] count;
    logic             overflow;
    logic             done;

    trace_capture #(
        .DATA_WIDTH  (DW),
        .PC_WIDTH    (PW),
        .NUM_CH      (NCH),
        .DEPTH       (DEP),
        .STOP_CYCLES (STOP)
    ) u_dut (
        .clock         (clk),
        .reset         (rst),
        .pc_i          (pc),
        .instruction_i (instr),
        .ch_data_i     (ch),
        .mode_i        (mode),
        .arm_i         (arm),
        .rd_ready_i    (ready),
        .rd_valid_o    (rd_valid),
        .rd_pc_o       (rd_pc),
        .rd_instr_o    (rd_instr),
        .rd_ch_o       (rd_ch),
        .count_o       (count),
        .overflow_o    (overflow),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of captured snapshots and window phase
    // ------------------------------------------------------------------
    typedef struct {
        logic [PW-1:0]  pc;
        logic [31:0]    instr;
        logic [CHW-1:0] ch;
    } ent_t;

    ent_t           mq[$];
    int             m_phase;    // 0 idle, 1 capturing, 2 done
    int             m_cyc;      // cycles already spent in the window
    logic [1:0]     m_mode;
    bit             m_first;
    bit             m_ovf;
    logic [PW-1:0]  m_prev_pc;
    logic [CHW-1:0] m_prev_ch;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit   pop;
        bit   full;
        bit   qual;
        ent_t e;
        pop  = (mq.size() != 0) && ready;
        full = (mq.size() == DEP);
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_cyc   = 0;
            m_ovf   = 0;
            m_first = 0;
        end else if (arm) begin
            mq.delete();
            m_phase = 1;
            m_cyc   = 0;
            m_ovf   = 0;
            m_first = 1;
            m_mode  = mode;
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_phase == 1) begin
                qual = m_first || (m_mode == 2'd0) || (m_mode == 2'd3) ||
                       ((m_mode == 2'd1) && (pc != m_prev_pc)) ||
                       ((m_mode == 2'd2) && (ch != m_prev_ch));
                if (qual) begin
                    if (!full || pop) begin
                        e.pc = pc; e.instr = instr; e.ch = ch;
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1;
                    end
                end
                m_first = 0;
                if (m_cyc == STOP - 1) m_phase = 2;
                else m_cyc++;
            end
        end
        m_prev_pc = pc;
        m_prev_ch = ch;
    endtask

    // Compare every observable output against the model
    task automatic check_all();
        chk("count", 64'(count), 64'(mq.size()));
        chk("valid", 64'(rd_valid), 64'(mq.size() != 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("done", 64'(done), 64'(m_phase == 2));
        if (mq.size() != 0) begin
            chk("head_pc", 64'(rd_pc), 64'(mq[0].pc));
            chk("head_instr", 64'(rd_instr), 64'(mq[0].instr));
            chk("head_ch", 64'(rd_ch), 64'(mq[0].ch));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [CHW-1:0] rnd_ch();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[CHW-1:0];
    endfunction

    initial begin
        logic [CHW-1:0] tmp_ch;
        rst = 1'b1; arm = 1'b0; mode = 2'd0; ready = 1'b0;
        pc = '0; instr = '0; ch = '0;
        m_phase = 0; m_cyc = 0; m_mode = 2'd0; m_first = 0; m_ovf = 0;
        m_prev_pc = '0; m_prev_ch = '0;

        // Reset state
        repeat (3) step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();

        // Every-cycle capture with no drain: fills, then overflows
        arm = 1'b1; mode = 2'd0; step(); arm = 1'b0;
        for (int i = 0; i < STOP; i++) begin
            pc = PW'(4 * i); instr = $urandom(); ch = rnd_ch();
            step();
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_done", 64'(done), 64'd1);
        chk("fill_head_pc", 64'(rd_pc), 64'd0);
        ready = 1'b1;
        repeat (DEP + 1) step();
        chk("drain_count", 64'(count), 64'd0);
        ready = 1'b0;

        // Reset in the middle of a capture window with 5 entries stored
        arm = 1'b1; mode = 2'd3; step(); arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pc = $urandom(); instr = $urandom(); ch = rnd_ch();
            step();
        end
        chk("mid_count", 64'(count), 64'd5);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(rd_valid), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (3) step();
        chk("idle_nowrite", 64'(count), 64'd0);

        // PC-change mode: 0x40 held three cycles, then 0x44
        arm = 1'b1; mode = 2'd1; step(); arm = 1'b0;
        for (int i = 0; i < STOP; i++) begin
            pc = (i < 3) ? 32'h40 : 32'h44; instr = $urandom(); ch = rnd_ch();
            step();
        end
        chk("pcmode_count", 64'(count), 64'd2);
        chk("pcmode_first", 64'(rd_pc), 64'h40);
        ready = 1'b1; step();
        chk("pcmode_second", 64'(rd_pc), 64'h44);
        step(); ready = 1'b0;

        // Channel-change mode: channel 1 goes 5 -> 9 once
        arm = 1'b1; mode = 2'd2; step(); arm = 1'b0;
        for (int i = 0; i < STOP; i++) begin
            tmp_ch = {16'h00a1, (i < 6) ? 16'd5 : 16'd9, 16'h00b2};
            ch = tmp_ch; pc = $urandom(); instr = $urandom();
            step();
        end
        chk("chmode_count", 64'(count), 64'd2);
        chk("chmode_first", 64'(rd_ch[31:16]), 64'd5);
        ready = 1'b1; step();
        chk("chmode_second", 64'(rd_ch[31:16]), 64'd9);
        step(); ready = 1'b0;

        // Full buffer with push and pop together, then re-arm with undrained data
        arm = 1'b1; mode = 2'd0; step(); arm = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            pc = $urandom(); instr = $urandom(); ch = rnd_ch(); step();
        end
        chk("pp_full", 64'(count), 64'd16);
        ready = 1'b1;
        for (int i = DEP; i < STOP; i++) begin
            pc = $urandom(); instr = $urandom(); ch = rnd_ch(); step();
        end
        chk("pp_count", 64'(count), 64'd16);
        chk("pp_ovf", 64'(overflow), 64'd0);
        chk("pp_done", 64'(done), 64'd1);
        repeat (12) step();
        ready = 1'b0; step();
        chk("undrained", 64'(count), 64'd4);
        // Re-arm while popping: flush wins
        arm = 1'b1; ready = 1'b1; step(); arm = 1'b0; ready = 1'b0;
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_ovf", 64'(overflow), 64'd0);
        chk("rearm_done", 64'(done), 64'd0);
        repeat (STOP + 2) begin
            pc = $urandom(); instr = $urandom(); ch = rnd_ch(); step();
        end

        // Random soak: arming, modes, back-pressure, occasional reset
        for (int i = 0; i < 1500; i++) begin
            arm   = ($urandom_range(0, 39) == 0);
            mode  = 2'($urandom_range(0, 3));
            ready = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1) == 0) pc = pc + 32'd4;
            if ($urandom_range(0, 3) == 0) begin
                tmp_ch = ch;
                tmp_ch[$urandom_range(0, CHW - 1)] = ~tmp_ch[$urandom_range(0, CHW - 1)];
                ch = tmp_ch;
            end
            instr = $urandom();
            step();
        end
        rst = 1'b0; arm = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_trace_capture
`default_nettype wire

// File: doc/trace_capture.md
# trace_capture

Synthesizable, parametrised trace-capture unit that sits beside `Processor` and records per-cycle snapshots of PC, instruction and a configurable set of watched register values into an on-chip buffer. Capture runs for a bounded number of cycles after arming, then stops; the buffer drains through a valid/ready readout port. It replaces fixed simulation-only register watching with hardware that works on FPGA and supports filtered (change-triggered) capture.

## Interface
Parameters:
- `DATA_WIDTH`, 64: width of each watched register channel.
- `PC_WIDTH`, 64: width of captured PC.
- `NUM_CH`, 3: number of watched register channels (≥1).
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `STOP_CYCLES`, 750: capture window length in clock cycles (≥1).

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_i`  in  PC_WIDTH  current PC.
- `instruction_i`  in  32  current instruction.
- `ch_data_i`  in  NUM_CH*DATA_WIDTH  watched registers, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `mode_i`  in  2  00 = every cycle, 01 = on PC change, 10 = on any channel change, 11 = reserved (treated as 00).
- `arm_i`  in  1  one-cycle pulse; starts a capture window.
- `rd_ready_i`  in  1  consumer accepts head entry.
- `rd_valid_o`  out  1  head entry available.
- `rd_pc_o`  out  PC_WIDTH  head PC.
- `rd_instr_o`  out  32  head instruction.
- `rd_ch_o`  out  NUM_CH*DATA_WIDTH  head channel values.
- `count_o`  out  $clog2(DEPTH)+1  entries held.
- `overflow_o`  out  1  sticky: ≥1 sample dropped because buffer full.
- `done_o`  out  1  capture window finished.

## Operation
- States: IDLE, CAPTURE, DONE. Reset → IDLE.
- IDLE: no writes. `arm_i` → CAPTURE; cycle counter ← 0; overflow cleared; buffer flushed; `mode_i` latched.
- CAPTURE: each cycle, sample qualifies if mode 00/11; mode 01 and `pc_i` ≠ previous-cycle `pc_i`; mode 10 and any channel ≠ previous-cycle value. First cycle of CAPTURE always qualifies (no valid previous value).
- Qualifying sample written if buffer not full, or full with a pop in the same cycle; otherwise dropped and `overflow_o` set.
- Cycle counter increments every CAPTURE cycle; when it reaches STOP_CYCLES−1, that cycle still samples, then → DONE.
- DONE: `done_o`=1, no writes; readout continues. `arm_i` → CAPTURE (re-arm, flushes buffer, including undrained entries).
- `arm_i` in CAPTURE: restarts window (counter 0, flush, overflow clear, mode relatched).
- Readout: show-ahead; `rd_valid_o` = not empty; pop on `rd_valid_o && rd_ready_i`. `rd_*` data undefined (but stable) when `rd_valid_o`=0.
- Pointers wrap modulo DEPTH; full when count = DEPTH.

## Timing
- Reset values: `rd_valid_o`=0, `count_o`=0, `overflow_o`=0, `done_o`=0, pointers 0, state IDLE. Reset mid-capture discards all entries.
- Write latency: sample on cycle n → `rd_valid_o`/`count_o` reflect it at n+1.
- Pop on cycle n → next entry (or `rd_valid_o`=0) at n+1.
- Simultaneous push/pop: count unchanged; when empty, push only (no bypass to output in same cycle).
- `arm_i` in same cycle as a pop: flush wins; count 0 at next cycle.
- `done_o` rises the cycle after the last capture cycle (arm at n → CAPTURE cycles n+1…n+STOP_CYCLES → `done_o` at n+STOP_CYCLES+1).

## Structure
- Package `trace_pkg`: state enum (IDLE/CAPTURE/DONE), mode constants (MODE_ALL, MODE_PC, MODE_CH).
- Sub-module `trace_fifo`: parametrised show-ahead sync FIFO (width PC_WIDTH+32+NUM_CH*DATA_WIDTH, depth DEPTH) with push/pop/flush/count/full/empty.
- Top holds FSM, cycle counter, previous-value registers, qualifier and overflow logic.

## Test plan
- Reset mid-capture with 5 entries stored → next cycle `count_o`=0, `rd_valid_o`=0, `done_o`=0, IDLE.
- Mode 00, STOP_CYCLES=10, DEPTH=16, `rd_ready_i`=1 after done → exactly 10 entries read, PCs 0,4,…,36 in order, `overflow_o`=0.
- Mode 00, STOP_CYCLES=20, DEPTH=16, `rd_ready_i`=0 → `count_o`=16, `overflow_o`=1, readout gives first 16 samples.
- Mode 01, PC held at 0x40 for 3 cycles then 0x44 → entries for 0x40 (first cycle) and 0x44 only.
- Mode 10, NUM_CH=3, channel 1 changes 5→9 once → exactly two entries (first cycle, change cycle) with rd_ch channel 1 = 5 then 9.
- Buffer full, push+pop same cycle → `count_o` stays 16, `overflow_o` stays 0; re-arm in DONE with 4 undrained → count 0, `overflow_o` cleared.
